// File: rtl/mem_ctrl_burst_pkg.sv
// Shared types and defaults for the burst memory controller.
// Holds the FSM state encoding and a width helper used by the counters.
package mem_ctrl_burst_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH_W = 9;
    localparam int DEF_BURST   = 4;
    localparam int DEF_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_burst_if.sv
// Cache-to-memory request/beat bus between cache_2wsa and mem_ctrl_burst.
// The cache side is the master; the memory controller is the slave.
interface mem_ctrl_burst_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rd_mem;
    logic              wr_mem;
    logic [ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0] data_mem_in;
    logic [DATA_W-1:0] data_mem_out;
    logic              beat_mem;
    logic              ready_mem;
    logic              busy_mem;

    modport master (
        output rd_mem, wr_mem, addr_mem, data_mem_in,
        input  data_mem_out, beat_mem, ready_mem, busy_mem
    );

    modport slave (
        input  rd_mem, wr_mem, addr_mem, data_mem_in,
        output data_mem_out, beat_mem, ready_mem, busy_mem
    );
endinterface

// File: rtl/mem_ctrl_burst_mem_array_sp.sv
// Single-port synchronous word array with a one-cycle, enable-gated read.
// The read register is reset and holds its value while re is low.
module mem_array_sp #(
    parameter int    DATA_W    = 16,
    parameter int    DEPTH_W   = 9,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic               re,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);
    logic [DATA_W-1:0] mem_r [0:(1<<DEPTH_W)-1];
    logic [DATA_W-1:0] rdata_r;

    // Array write port; reset deliberately leaves contents untouched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/mem_ctrl_burst.sv
// Main-memory controller: one line-fill or write-back at a time, fixed access
// latency, BURST beats on the data path, then a one-cycle ready pulse.
module mem_ctrl_burst
    import mem_ctrl_burst_pkg::*;
#(
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH_W   = DEF_DEPTH_W,
    parameter int    BURST     = DEF_BURST,
    parameter int    LATENCY   = DEF_LATENCY,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_ctrl_burst_if.slave    bus
);
    localparam int BEAT_W = idx_width(BURST);
    localparam int CNT_W  = idx_width(LATENCY);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    state_e                    state_r;
    logic [CNT_W-1:0]          lat_cnt_r;
    logic [BEAT_W-1:0]         beat_idx_r;
    logic [DEPTH_W-BEAT_W-1:0] base_r;
    logic                      dir_wr_r;
    logic                      beat_r;
    logic                      ready_r;
    logic                      busy_r;

    logic                      ram_we_s;
    logic                      ram_re_s;
    logic [BEAT_W-1:0]         line_idx_s;
    logic [DEPTH_W-1:0]        ram_addr_s;
    logic [DATA_W-1:0]         ram_rdata_s;
    logic                      unused_addr_s;

    // Line offset and upper address bits take no part in array indexing.
    assign unused_addr_s = ^{bus.addr_mem[ADDR_W-1:DEPTH_W], bus.addr_mem[BEAT_W-1:0]};

    // Transaction FSM with latency/beat counters, base latch and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= {CNT_W{1'b0}};
            beat_idx_r <= {BEAT_W{1'b0}};
            base_r     <= {(DEPTH_W-BEAT_W){1'b0}};
            dir_wr_r   <= 1'b0;
            beat_r     <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_r  <= 1'b0;
                    ready_r <= 1'b0;
                    if (bus.wr_mem || bus.rd_mem) begin
                        state_r    <= ST_WAIT;
                        base_r     <= bus.addr_mem[DEPTH_W-1:BEAT_W];
                        dir_wr_r   <= bus.wr_mem;
                        lat_cnt_r  <= CNT_W'(LATENCY - 1);
                        beat_idx_r <= {BEAT_W{1'b0}};
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_XFER;
                        beat_r  <= 1'b1;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (beat_idx_r == BEAT_LAST) begin
                        state_r <= ST_DONE;
                        beat_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        beat_idx_r <= beat_idx_r + BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    beat_r  <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Reads are issued one cycle ahead so the registered word lines up with beat_mem.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_re_s   = 1'b0;
        line_idx_s = beat_idx_r;
        if (dir_wr_r && state_r == ST_XFER) begin
            ram_we_s   = 1'b1;
            line_idx_s = beat_idx_r;
        end else if (!dir_wr_r && state_r == ST_WAIT && lat_cnt_r == {CNT_W{1'b0}}) begin
            ram_re_s   = 1'b1;
            line_idx_s = {BEAT_W{1'b0}};
        end else if (!dir_wr_r && state_r == ST_XFER && beat_idx_r != BEAT_LAST) begin
            ram_re_s   = 1'b1;
            line_idx_s = beat_idx_r + BEAT_W'(1);
        end else begin
            ram_we_s   = 1'b0;
            ram_re_s   = 1'b0;
        end
    end

    assign ram_addr_s = {base_r, line_idx_s};

    mem_array_sp #(
        .DATA_W    (DATA_W),
        .DEPTH_W   (DEPTH_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (bus.data_mem_in),
        .rdata (ram_rdata_s)
    );

    assign bus.data_mem_out = ram_rdata_s;
    assign bus.beat_mem     = beat_r;
    assign bus.ready_mem    = ready_r;
    assign bus.busy_mem     = busy_r;
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Scoreboard bench for mem_ctrl_burst: a bench-side word model feeds expected
// read beats into a queue that is drained as the DUT produces beats.
module tb_mem_ctrl_burst;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] model [0:511];
    bit          dc_m  [0:511];
    logic [16:0] exp_q [$];

    mem_ctrl_burst_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_ctrl_burst #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_W(9), .BURST(4), .LATENCY(3), .INIT_FILE("")
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request sampled at the next rising edge; checks cycles 0..8.
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [63:0] wwords, input bit keep, input bit drop_in_wait);
        logic [8:0]  base;
        logic [16:0] e;
        logic [15:0] w;
        base = addr[8:0] & 9'h1fc;
        bus.rd_mem   = rd;
        bus.wr_mem   = wr;
        bus.addr_mem = addr;
        if (rd && !wr) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({dc_m[base + 9'(i)], model[base + 9'(i)]});
        end
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0 && drop_in_wait) begin
                bus.rd_mem   = 1'b0;
                bus.wr_mem   = 1'b0;
                bus.addr_mem = 16'h0155;
            end
            check_eq("beat", bus.beat_mem, (c >= 3 && c <= 6));
            check_eq("ready", bus.ready_mem, (c == 7));
            if (c <= 6) check_eq("busy", bus.busy_mem, 1);
            if (c >= 3 && c <= 6) begin
                if (wr) begin
                    w = wwords[16*(c-3) +: 16];
                    bus.data_mem_in = w;
                    model[base + 9'(c-3)] = w;
                    dc_m[base + 9'(c-3)]  = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check_eq("q_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (!e[16]) check_eq("rdata", bus.data_mem_out, {16'h0, e[15:0]});
                end
            end
            if (c == 7 && !keep) begin
                bus.rd_mem = 1'b0;
                bus.wr_mem = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("idle_busy", bus.busy_mem, 0);
        check_eq("idle_ready", bus.ready_mem, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            model[i] = 16'h0;
            dc_m[i]  = 1'b1;
        end
        reset_n          = 1'b0;
        bus.rd_mem       = 1'b0;
        bus.wr_mem       = 1'b0;
        bus.addr_mem     = 16'h0;
        bus.data_mem_in  = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_beat", bus.beat_mem, 0);
        check_eq("rst_ready", bus.ready_mem, 0);
        check_eq("rst_busy", bus.busy_mem, 0);
        check_eq("rst_data", bus.data_mem_out, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Preload line 0x40 then fill from an unaligned address in the line.
        do_txn(1'b0, 1'b1, 16'h0040, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0042, 64'h0, 1'b0, 1'b0);

        // Write-back then read-back.
        do_txn(1'b0, 1'b1, 16'h0010, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0010, 64'h0, 1'b0, 1'b0);

        // Simultaneous read and write: the write wins, single ready pulse.
        do_txn(1'b1, 1'b1, 16'h0020, {16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678}, 1'b0, 1'b0);
        check_eq("no_extra_ready", bus.ready_mem, 0);
        do_txn(1'b1, 1'b0, 16'h0021, 64'h0, 1'b0, 1'b0);

        // Reset during the second beat of a write to 0x30.
        do_txn(1'b0, 1'b1, 16'h0030, {16'h0808, 16'h0707, 16'h0606, 16'h0505}, 1'b0, 1'b0);
        bus.wr_mem   = 1'b1;
        bus.addr_mem = 16'h0030;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.data_mem_in = 16'hC0DE;
                model[9'h030]   = 16'hC0DE;
            end
            if (c == 4) begin
                bus.data_mem_in = 16'hD00D;
                dc_m[9'h031]    = 1'b1;
            end
        end
        check_eq("pre_rst_beat", bus.beat_mem, 1);
        reset_n    = 1'b0;
        bus.wr_mem = 1'b0;
        #1;
        check_eq("mid_rst_beat", bus.beat_mem, 0);
        check_eq("mid_rst_busy", bus.busy_mem, 0);
        check_eq("mid_rst_ready", bus.ready_mem, 0);
        check_eq("mid_rst_data", bus.data_mem_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("post_rst_ready", bus.ready_mem, 0);
        end
        do_txn(1'b1, 1'b0, 16'h0030, 64'h0, 1'b0, 1'b0);

        // Request held across ready: back-to-back, second one aliases 0x240 onto 0x040.
        do_txn(1'b1, 1'b0, 16'h0040, 64'h0, 1'b1, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0240, 64'h0, 1'b0, 1'b0);

        // Address change and request drop during WAIT do not disturb the latched line.
        do_txn(1'b1, 1'b0, 16'h0012, 64'h0, 1'b0, 1'b1);

        check_eq("q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
